// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage and the ALU itself.
//   aluop_e   : 4-bit ALU opcode; [3:2] selects arith/logic/shift/compare unit
//   OP..AUIPC : RV64I major opcodes decoded by the issue stage
//   F3_*/F7_* : funct3/funct7 field values
//   f3_aluop  : maps funct3 (plus the SUB/SRA alternate bit) to an aluop
package alu_pkg;

    typedef enum logic [3:0] {
        ALUOP_ADD  = 4'b0000,
        ALUOP_SUB  = 4'b0001,
        ALUOP_XOR  = 4'b0100,
        ALUOP_OR   = 4'b0110,
        ALUOP_AND  = 4'b0111,
        ALUOP_SLL  = 4'b1000,
        ALUOP_SRL  = 4'b1001,
        ALUOP_SRA  = 4'b1011,
        ALUOP_SLT  = 4'b1100,
        ALUOP_SLTU = 4'b1110
    } aluop_e;

    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // alt selects SUB over ADD and SRA over SRL; ignored for other funct3.
    function automatic aluop_e f3_aluop(input logic [2:0] f3, input logic alt);
        aluop_e r;
        r = ALUOP_ADD;
        case (f3)
            F3_ADD_SUB: r = alt ? ALUOP_SUB : ALUOP_ADD;
            F3_SLL:     r = ALUOP_SLL;
            F3_SLT:     r = ALUOP_SLT;
            F3_SLTU:    r = ALUOP_SLTU;
            F3_XOR:     r = ALUOP_XOR;
            F3_SRL_SRA: r = alt ? ALUOP_SRA : ALUOP_SRL;
            F3_OR:      r = ALUOP_OR;
            F3_AND:     r = ALUOP_AND;
            default:    r = ALUOP_ADD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV64I decoder for the ALU issue stage.
//   i_inst      : instruction word
//   i_pc        : instruction address (AUIPC operand)
//   i_rs1_data  : rs1 read data
//   i_rs2_data  : rs2 read data
//   o_aluop     : ALU opcode
//   o_op1/o_op2 : ALU operands
//   o_rd        : destination register field
//   o_wen       : write rd (clear for x0 or illegal)
//   o_word      : 32-bit W-op
//   o_illegal   : undecodable instruction
module alu_decode
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    output logic [3:0]      o_aluop,
    output logic [XLEN-1:0] o_op1,
    output logic [XLEN-1:0] o_op2,
    output logic [4:0]      o_rd,
    output logic            o_wen,
    output logic            o_word,
    output logic            o_illegal
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [5:0]      w_f6;
    logic            w_f7_alt;
    logic            w_f7_ok;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_shamt6;
    logic [XLEN-1:0] w_shamt5;

    aluop_e          w_aluop;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic            w_word;
    logic            w_illegal;

    assign w_opcode = i_inst[6:0];
    assign w_f3     = i_inst[14:12];
    assign w_f7     = i_inst[31:25];
    assign w_f6     = i_inst[31:26];
    assign w_f7_alt = (w_f7 == F7_ALT);
    // The alternate funct7 is only meaningful for ADD/SUB and SRL/SRA.
    assign w_f7_ok  = (w_f7 == F7_BASE) ||
                      (w_f7_alt && (w_f3 == F3_ADD_SUB || w_f3 == F3_SRL_SRA));

    assign w_imm_i  = {{(XLEN-12){i_inst[31]}}, i_inst[31:20]};
    assign w_imm_u  = {{(XLEN-32){i_inst[31]}}, i_inst[31:12], 12'b0};
    assign w_shamt6 = {{(XLEN-6){1'b0}}, i_inst[25:20]};
    assign w_shamt5 = {{(XLEN-5){1'b0}}, i_inst[24:20]};

    always_comb begin
        w_aluop   = ALUOP_ADD;
        w_op1     = i_rs1_data;
        w_op2     = i_rs2_data;
        w_word    = 1'b0;
        w_illegal = 1'b0;
        case (w_opcode)
            OP: begin
                w_aluop   = f3_aluop(w_f3, w_f7_alt);
                w_illegal = !w_f7_ok;
            end
            OP_32: begin
                w_aluop   = f3_aluop(w_f3, w_f7_alt);
                w_word    = 1'b1;
                w_illegal = !w_f7_ok ||
                            !(w_f3 == F3_ADD_SUB || w_f3 == F3_SLL || w_f3 == F3_SRL_SRA);
            end
            OP_IMM: begin
                if (w_f3 == F3_SLL || w_f3 == F3_SRL_SRA) begin
                    // RV64 shifts: funct6 sits above a 6-bit shamt.
                    w_aluop   = f3_aluop(w_f3, i_inst[30]);
                    w_op2     = w_shamt6;
                    w_illegal = !((w_f6 == 6'b000000) ||
                                  (w_f6 == 6'b010000 && w_f3 == F3_SRL_SRA));
                end else begin
                    w_aluop = f3_aluop(w_f3, 1'b0);
                    w_op2   = w_imm_i;
                end
            end
            OP_IMM_32: begin
                w_word = 1'b1;
                case (w_f3)
                    F3_ADD_SUB: begin
                        w_aluop = ALUOP_ADD;
                        w_op2   = w_imm_i;
                    end
                    F3_SLL, F3_SRL_SRA: begin
                        // Full funct7 check also rejects inst[25]=1.
                        w_aluop   = f3_aluop(w_f3, i_inst[30]);
                        w_op2     = w_shamt5;
                        w_illegal = !w_f7_ok;
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            LUI: begin
                w_op1 = '0;
                w_op2 = w_imm_u;
            end
            AUIPC: begin
                w_op1 = i_pc;
                w_op2 = w_imm_u;
            end
            default: w_illegal = 1'b1;
        endcase
        if (i_inst[1:0] != 2'b11) begin
            w_illegal = 1'b1;
        end
    end

    assign o_aluop   = w_illegal ? ALUOP_ADD : w_aluop;
    assign o_op1     = w_illegal ? '0 : w_op1;
    assign o_op2     = w_illegal ? '0 : w_op2;
    assign o_rd      = i_inst[11:7];
    assign o_wen     = !w_illegal && (i_inst[11:7] != 5'd0);
    assign o_word    = w_illegal ? 1'b0 : w_word;
    assign o_illegal = w_illegal;

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue register in front of the 64-bit ALU.
//   clk, rst              : clock, synchronous active-high reset
//   flush                 : kill held entry, drop this cycle's input
//   in_valid/in_ready     : fetch handshake; in_inst, in_pc payload
//   rs1_addr/rs2_addr     : regfile read addresses (combinational)
//   rs1_data/rs2_data     : regfile read data, same cycle
//   out_valid/out_ready   : execute handshake
//   out_aluop..out_pc     : registered decoded entry
//   cnt_issued/cnt_illegal: transfer counters, wrap silently
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_aluop,
    output logic [XLEN-1:0]  out_op1,
    output logic [XLEN-1:0]  out_op2,
    output logic [4:0]       out_rd,
    output logic             out_wen,
    output logic             out_word,
    output logic             out_illegal,
    output logic [XLEN-1:0]  out_pc,
    output logic [CNT_W-1:0] cnt_issued,
    output logic [CNT_W-1:0] cnt_illegal
);

    logic [3:0]       w_aluop;
    logic [XLEN-1:0]  w_op1;
    logic [XLEN-1:0]  w_op2;
    logic [4:0]       w_rd;
    logic             w_wen;
    logic             w_word;
    logic             w_illegal;
    logic             w_in_ready;
    logic             w_capture;
    logic             w_transfer;

    logic             r_valid;
    logic [3:0]       r_aluop;
    logic [XLEN-1:0]  r_op1;
    logic [XLEN-1:0]  r_op2;
    logic [4:0]       r_rd;
    logic             r_wen;
    logic             r_word;
    logic             r_illegal;
    logic [XLEN-1:0]  r_pc;
    logic [CNT_W-1:0] r_cnt_issued;
    logic [CNT_W-1:0] r_cnt_illegal;

    alu_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .i_inst     (in_inst),
        .i_pc       (in_pc),
        .i_rs1_data (rs1_data),
        .i_rs2_data (rs2_data),
        .o_aluop    (w_aluop),
        .o_op1      (w_op1),
        .o_op2      (w_op2),
        .o_rd       (w_rd),
        .o_wen      (w_wen),
        .o_word     (w_word),
        .o_illegal  (w_illegal)
    );

    assign rs1_addr   = in_inst[19:15];
    assign rs2_addr   = in_inst[24:20];
    assign w_in_ready = !r_valid || out_ready;
    assign w_capture  = in_valid && w_in_ready && !flush;
    // A flushed entry never counts as transferred.
    assign w_transfer = r_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid       <= 1'b0;
            r_aluop       <= ALUOP_ADD;
            r_op1         <= '0;
            r_op2         <= '0;
            r_rd          <= '0;
            r_wen         <= 1'b0;
            r_word        <= 1'b0;
            r_illegal     <= 1'b0;
            r_pc          <= '0;
            r_cnt_issued  <= '0;
            r_cnt_illegal <= '0;
        end else begin
            if (w_capture) begin
                r_valid   <= 1'b1;
                r_aluop   <= w_aluop;
                r_op1     <= w_op1;
                r_op2     <= w_op2;
                r_rd      <= w_rd;
                r_wen     <= w_wen;
                r_word    <= w_word;
                r_illegal <= w_illegal;
                r_pc      <= in_pc;
            end else if (w_transfer || flush) begin
                r_valid <= 1'b0;
            end
            if (w_transfer) begin
                r_cnt_issued <= r_cnt_issued + CNT_W'(1);
                if (r_illegal) begin
                    r_cnt_illegal <= r_cnt_illegal + CNT_W'(1);
                end
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_valid;
    assign out_aluop   = r_aluop;
    assign out_op1     = r_op1;
    assign out_op2     = r_op2;
    assign out_rd      = r_rd;
    assign out_wen     = r_wen;
    assign out_word    = r_word;
    assign out_illegal = r_illegal;
    assign out_pc      = r_pc;
    assign cnt_issued  = r_cnt_issued;
    assign cnt_illegal = r_cnt_illegal;

endmodule
